// File: rtl/tdc_pkg.sv
// Shared constants for the TDC-GPX timestamp path.
// Holds the START marker word, the I-mode hit field positions and the
// framer state encoding. The histogramming controller imports the same
// marker and field constants, so the two blocks cannot disagree on format.
package tdc_pkg;

  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  localparam int unsigned CH_MSB    = 27;
  localparam int unsigned CH_LSB    = 26;
  localparam int unsigned START_MSB = 25;
  localparam int unsigned START_LSB = 18;
  localparam int unsigned SLOPE_BIT = 17;
  localparam int unsigned TIME_MSB  = 16;
  localparam int unsigned TIME_LSB  = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HIT   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [7:0] start_of(input logic [27:0] w);
    return w[START_MSB:START_LSB];
  endfunction

  // The zero top nibble keeps a hit word from ever aliasing MARKER.
  function automatic logic [31:0] hit_word(input logic [27:0] w);
    return {4'h0, w};
  endfunction

endpackage

// File: rtl/tdc_event_framer_timeout.sv
// event_timeout_counter: idle-cycle counter for the open event.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear_i      return count to zero (has priority over counting)
//   count_en_i   advance by one, saturating at LIMIT-1
//   tmo_o        count has reached LIMIT-1
module event_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic tmo_o
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear_i) begin
      timer_d = '0;
    end else if (count_en_i && (timer_q != LAST)) begin
      timer_d = timer_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign tmo_o = (timer_q == LAST);

endmodule

// File: rtl/tdc_event_framer.sv
// tdc_event_framer: frames raw TDC-GPX I-mode hits into the timestamp FIFO.
// Writes {4'h0, hit} per hit and MARKER at every event boundary (start
// number change, inactivity timeout, or enable falling with an event open).
// Caps hits per event at MAX_HITS and counts the discarded ones.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   enable                 framing enable; low drains and discards input
//   tdc_data/valid/ready   28-bit hit word handshake
//   fifo_din, fifo_wr_en   registered FIFO write port
//   fifo_full              FIFO programmable-full (>= 2 entries margin)
//   event_count            markers written (wrapping)
//   drop_count             hits dropped by the cap (saturating)
module tdc_event_framer
  import tdc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_HITS       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [27:0] tdc_data,
  input  logic        tdc_valid,
  output logic        tdc_ready,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic [31:0] event_count,
  output logic [15:0] drop_count
);

  localparam logic [3:0] HIT_CAP = 4'(MAX_HITS);

  state_e      state_q, state_d;
  logic        open_q, open_d;
  logic [7:0]  cur_start_q, cur_start_d;
  logic [3:0]  nhits_q, nhits_d;
  logic [27:0] hold_q, hold_d;
  logic [31:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic [31:0] ev_q, ev_d;
  logic [15:0] drop_q, drop_d;
  logic        rdy_en_q;
  logic        tmo_flag, tmo, accept, cnt_en;

  event_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wr_d),
    .count_en_i(cnt_en),
    .tmo_o     (tmo_flag)
  );

  assign tmo = open_q & tmo_flag;

  always_comb begin
    state_d     = state_q;
    open_d      = open_q;
    cur_start_d = cur_start_q;
    nhits_d     = nhits_q;
    hold_d      = hold_q;
    din_d       = din_q;
    wr_d        = 1'b0;
    ev_d        = ev_q;
    drop_d      = drop_q;
    tdc_ready   = 1'b0;
    cnt_en      = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      RUN: begin
        // rdy_en_q holds ready low until the first clock after reset.
        tdc_ready = rdy_en_q & (enable ? (~fifo_full & ~tmo) : 1'b1);
        accept    = tdc_valid & tdc_ready;
        if (!enable) begin
          if (open_q) state_d = FLUSH;
        end else if (accept) begin
          if (!open_q || (start_of(tdc_data) != cur_start_q)) begin
            wr_d        = 1'b1;
            din_d       = MARKER;
            ev_d        = ev_q + 32'd1;
            hold_d      = tdc_data;
            cur_start_d = start_of(tdc_data);
            state_d     = HIT;
          end else if (nhits_q < HIT_CAP) begin
            wr_d    = 1'b1;
            din_d   = hit_word(tdc_data);
            nhits_d = nhits_q + 4'd1;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end else if (tmo && !fifo_full) begin
          wr_d    = 1'b1;
          din_d   = MARKER;
          ev_d    = ev_q + 32'd1;
          open_d  = 1'b0;
          nhits_d = '0;
        end
        cnt_en = open_q & ~wr_d;
      end
      HIT: begin
        if (!fifo_full) begin
          wr_d    = 1'b1;
          din_d   = hit_word(hold_q);
          open_d  = 1'b1;
          nhits_d = 4'd1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (!fifo_full) begin
          wr_d    = 1'b1;
          din_d   = MARKER;
          ev_d    = ev_q + 32'd1;
          open_d  = 1'b0;
          nhits_d = '0;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      open_q      <= 1'b0;
      cur_start_q <= '0;
      nhits_q     <= '0;
      hold_q      <= '0;
      din_q       <= '0;
      wr_q        <= 1'b0;
      ev_q        <= '0;
      drop_q      <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      open_q      <= open_d;
      cur_start_q <= cur_start_d;
      nhits_q     <= nhits_d;
      hold_q      <= hold_d;
      din_q       <= din_d;
      wr_q        <= wr_d;
      ev_q        <= ev_d;
      drop_q      <= drop_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign fifo_din    = din_q;
  assign fifo_wr_en  = wr_q;
  assign event_count = ev_q;
  assign drop_count  = drop_q;

endmodule

// File: doc/tdc_event_framer.md
# tdc_event_framer

Sits between the TDC-GPX core controller and the timestamp FIFO read by the histogramming controller. It accepts raw 28-bit TDC-GPX I-mode hit words and writes them to the FIFO as 32-bit words, inserting the all-ones START marker (32'hFFFFFFFF) at every event boundary. An event boundary is a start-number change or an inactivity timeout. The block caps hits per event and counts discarded words, so the downstream 4-hit coincidence logic always sees well-formed events.

## Interface
- TIMEOUT_CYCLES, 1024: idle cycles after the last written hit before the open event is closed with a marker.
- MAX_HITS, 8: hits forwarded per event; later hits in the same event are dropped.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  framing enable; when low, input is drained and discarded.
- tdc_data  in  28  [27:26] channel, [25:18] start number, [17] slope, [16:0] hit time.
- tdc_valid  in  1  tdc_data valid.
- tdc_ready  out  1  word accepted when tdc_valid & tdc_ready.
- fifo_din  out  32  FIFO write data (registered).
- fifo_wr_en  out  1  FIFO write strobe (registered, one word per cycle).
- fifo_full  in  1  FIFO programmable-full; asserts with at least 2 free entries remaining.
- event_count  out  32  markers written, wrapping.
- drop_count  out  16  hits discarded by the MAX_HITS cap, saturating at 16'hFFFF.

## Operation
- Hit word format: fifo_din = {4'h0, tdc_data}. The top nibble is zero, so a hit can never alias the marker.
- State registers:
  - open: an event is in progress.
  - cur_start (8 bits).
  - nhits (4 bits).
  - hold (28 bits).
  - timer: sized clog2(TIMEOUT_CYCLES).
- FSM states:
  - RUN: tdc_ready = enable ? (~fifo_full & ~tmo) : 1, where tmo = open & (timer == TIMEOUT_CYCLES-1). On an accepted word, exactly one of the following applies:
    - enable=0: discard, not counted.
    - ~open, or start != cur_start: write marker, hold <= tdc_data, cur_start <= start, go to HIT.
    - Same start and nhits < MAX_HITS: write hit, nhits++, timer <= 0.
    - Same start and nhits == MAX_HITS: discard, drop_count++ (saturating).
  - RUN with tmo and no accept: write marker, open <= 0, nhits <= 0.
  - HIT: tdc_ready=0. When ~fifo_full, write hold, open <= 1, nhits <= 1, timer <= 0, go to RUN.
  - FLUSH: entered from RUN when enable falls while open. tdc_ready=0. When ~fifo_full, write marker, open <= 0, nhits <= 0, go to RUN.
- Marker precedence:
  - A marker is written only when an event boundary is reached.
  - A marker preceding the first hit after reset or after a timeout is still written. Downstream treats an empty event as a clear.
- event_count increments on every marker write.
- timer counts only while open, in RUN, with no write that cycle. It saturates at TIMEOUT_CYCLES-1.
- Reset mid-operation: all state clears immediately. A held hit or pending marker is lost, and no partial write is issued.

## Timing
- Reset values:
  - tdc_ready=0, fifo_wr_en=0, fifo_din=0.
  - event_count=0, drop_count=0.
  - State RUN, open=0, nhits=0, timer=0, cur_start=0, hold=0.
- Same-event hit: fifo_wr_en is high on the cycle after acceptance.
- New-event hit: the marker is written on cycle +1 and the hit on cycle +2 or later. tdc_ready is low for at least one cycle.
- Throughput: one hit per cycle within an event.
- fifo_full is sampled in the cycle before each registered write; the 2-entry margin of programmable-full absorbs the one in-flight word.
- Timeout marker: written on the first cycle where timer == TIMEOUT_CYCLES-1 and no input is accepted. An input and a timeout in the same cycle cannot both proceed, because tdc_ready is forced low when tmo is set.
- enable is synchronous. Its falling edge is seen on the next clock. Words accepted in that same cycle are still framed.

## Structure
- Shared package tdc_pkg holds:
  - MARKER = 32'hFFFFFFFF.
  - Field positions: CH 27:26, START 25:18, SLOPE 17, TIME 16:0.
  - State encoding {RUN, HIT, FLUSH}.
- The histogramming controller imports the same MARKER and field constants.
- One sub-module: event_timeout_counter, providing clear, count enable and saturation, with a tmo flag output.

## Test plan
- Four hits with start 0x05 on channels 0-3, then a fifth with start 0x06 -> FIFO holds marker, 0x00140xxx…, then marker, then the start-0x06 hit. event_count=2.
- Ten hits with identical start, MAX_HITS=8 -> FIFO holds marker + 8 hits. drop_count=2. Hits 9 and 10 are absent.
- One hit, then no input for TIMEOUT_CYCLES -> marker written exactly TIMEOUT_CYCLES cycles after the hit write. open clears.
- fifo_full held high for 20 cycles during a new-event accept -> marker and hit are each written only after full deasserts. Order is preserved and no words are lost or duplicated.
- enable drops with an event open -> FLUSH writes one marker. Words arriving while enable=0 are acknowledged and never written.
- reset pulsed while in HIT -> fifo_wr_en=0 from the reset edge. The held hit is never written, and counters read 0.
